// File: rtl/frac_clk_en_gen_pkg.sv
// frac_clk_en_gen_pkg: shared clock constants, lock FSM states and a clog2 helper
package frac_clk_en_gen_pkg;

    localparam int FPGA_CLK_HZ = 27000000;
    localparam int GB_CPU_HZ   = 4194304;
    localparam logic [51:0] DEF_INC_VEC = {2{26'd4194304}};

    typedef enum logic {LOCKING, LOCKED} lock_state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/frac_acc_ch.sv
// frac_acc_ch: one modulo accumulator producing a registered INC/MOD clock-enable and toggle
module frac_acc_ch #(
    parameter int ACC_W = 26,
    parameter int MOD = 27000000,
    parameter logic [ACC_W-1:0] INC = ACC_W'(4194304)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ce,
    output logic tgl
);

    localparam logic [ACC_W-1:0] M = ACC_W'(MOD);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic wrap;

    // width rule 2^ACC_W > 2*MOD guarantees the sum never overflows
    always_comb begin
        sum = acc + INC;
        wrap = sum >= M;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ce <= 1'b0;
            tgl <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ce <= 1'b0;
            tgl <= 1'b0;
        end else if (en) begin
            acc <= wrap ? sum - M : sum;
            ce <= wrap;
            tgl <= tgl ^ wrap;
        end else begin
            ce <= 1'b0;
        end
    end

endmodule

// File: rtl/frac_clk_en_gen.sv
// frac_clk_en_gen: NUM_CH fractional clock-enable channels gated by a post-reset lock counter
module frac_clk_en_gen
    import frac_clk_en_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int MOD = FPGA_CLK_HZ,
    parameter int ACC_W = 26,
    parameter logic [NUM_CH*ACC_W-1:0] INC_VEC = DEF_INC_VEC,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] run,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] tgl,
    output logic              ready
);

    localparam int LCW = clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LAST = LCW'(LOCK_CYCLES - 1);

    lock_state_t state, state_n;
    logic [LCW-1:0] cnt, cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOCKING;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = (state == LOCKING && cnt == LAST) ? LOCKED : state;
        cnt_n = (state == LOCKING) ? cnt + 1'b1 : cnt;
    end

    assign ready = state == LOCKED;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        frac_acc_ch #(
            .ACC_W(ACC_W),
            .MOD(MOD),
            .INC(INC_VEC[i*ACC_W +: ACC_W])
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .en(ready & run[i]),
            .clr(sync_clr),
            .ce(ce[i]),
            .tgl(tgl[i])
        );
    end

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// tb_frac_clk_en_gen: table and scoreboard checks of lock, fraction, freeze, clear, reset and rate
module tb_frac_clk_en_gen;

    typedef struct {
        logic [2:0] run;
        logic       clr;
        logic [2:0] ce;
        logic [2:0] tgl;
        logic       rdy;
    } vec_t;

    typedef struct {
        logic [2:0] ce;
        logic [2:0] tgl;
        logic       rdy;
        int         tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_r = 1'b1;
    logic [2:0] run = 3'b111;
    logic sync_clr = 1'b0;
    logic [2:0] ce, tgl;
    logic ready;
    logic ce_r, tgl_r, ready_r;

    int checks = 0;
    int errors = 0;
    int rate_cnt = 0;
    bit rate_done = 0;
    bit rate_locked = 0;

    vec_t tbl [16];
    exp_t q [$];
    int macc [3];
    int mtgl [3];
    int minc [3];

    always #5 clk = ~clk;

    frac_clk_en_gen #(
        .NUM_CH(3), .MOD(10), .ACC_W(5),
        .INC_VEC({5'd10, 5'd5, 5'd3}), .LOCK_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .sync_clr(sync_clr),
        .ce(ce), .tgl(tgl), .ready(ready)
    );

    frac_clk_en_gen #(
        .NUM_CH(1), .MOD(27000000), .ACC_W(26),
        .INC_VEC(26'd4194304), .LOCK_CYCLES(16)
    ) dut_rate (
        .clk(clk), .rst(rst_r), .run(1'b1), .sync_clr(1'b0),
        .ce(ce_r), .tgl(tgl_r), .ready(ready_r)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, want);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        chk($sformatf("ce[%0d]", e.tag), 32'(ce), 32'(e.ce));
        chk($sformatf("tgl[%0d]", e.tag), 32'(tgl), 32'(e.tgl));
        chk($sformatf("ready[%0d]", e.tag), 32'(ready), 32'(e.rdy));
    endtask

    task automatic apply(input logic [2:0] r, input logic c, input exp_t e);
        @(negedge clk);
        pop_chk();
        run = r;
        sync_clr = c;
        q.push_back(e);
    endtask

    task automatic apply_m(input logic [2:0] r, input logic c, input int tag);
        exp_t e;
        e.rdy = 1'b1;
        e.tag = tag;
        for (int i = 0; i < 3; i++) begin
            e.ce[i] = 1'b0;
            if (c) begin
                macc[i] = 0;
                mtgl[i] = 0;
            end else if (r[i]) begin
                macc[i] += minc[i];
                if (macc[i] >= 10) begin
                    macc[i] -= 10;
                    mtgl[i] ^= 1;
                    e.ce[i] = 1'b1;
                end
            end
            e.tgl[i] = mtgl[i][0];
        end
        apply(r, c, e);
    endtask

    task automatic run_table(input int base);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.ce = tbl[k].ce;
            e.tgl = tbl[k].tgl;
            e.rdy = tbl[k].rdy;
            e.tag = base + k;
            apply(tbl[k].run, tbl[k].clr, e);
        end
    endtask

    initial begin
        for (int k = 0; k < 27000; k++) begin
            if (k == 3) rst_r = 1'b0;
            @(negedge clk);
            if (ready_r) break;
        end
        rate_locked = ready_r;
        if (ready_r)
            for (int k = 0; k < 27000; k++) begin
                @(negedge clk);
                rate_cnt += int'(ce_r);
            end
        rate_done = 1;
    end

    initial begin
        minc = '{3, 5, 10};
        tbl[0]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[2]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
        tbl[3]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b1};
        tbl[4]  = '{3'b111, 1'b0, 3'b100, 3'b100, 1'b1};
        tbl[5]  = '{3'b111, 1'b0, 3'b110, 3'b010, 1'b1};
        tbl[6]  = '{3'b111, 1'b0, 3'b100, 3'b110, 1'b1};
        tbl[7]  = '{3'b111, 1'b0, 3'b111, 3'b001, 1'b1};
        tbl[8]  = '{3'b111, 1'b0, 3'b100, 3'b101, 1'b1};
        tbl[9]  = '{3'b111, 1'b0, 3'b110, 3'b011, 1'b1};
        tbl[10] = '{3'b111, 1'b0, 3'b101, 3'b110, 1'b1};
        tbl[11] = '{3'b111, 1'b0, 3'b110, 3'b000, 1'b1};
        tbl[12] = '{3'b111, 1'b0, 3'b100, 3'b100, 1'b1};
        tbl[13] = '{3'b111, 1'b0, 3'b111, 3'b011, 1'b1};
        tbl[14] = '{3'b111, 1'b0, 3'b100, 3'b111, 1'b1};
        tbl[15] = '{3'b111, 1'b0, 3'b110, 3'b001, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_ce", 32'(ce), 0);
        chk("rst_tgl", 32'(tgl), 0);
        chk("rst_ready", 32'(ready), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_table(0);

        // state left by the table: acc = {0,0,6}, tgl = {0,0,1}
        macc = '{6, 0, 0};
        mtgl = '{1, 0, 0};
        for (int k = 0; k < 3; k++) apply_m(3'b111, 1'b0, 100 + k);
        for (int k = 0; k < 7; k++) apply_m(3'b110, 1'b0, 200 + k);
        for (int k = 0; k < 10; k++) apply_m(3'b111, 1'b0, 300 + k);
        apply_m(3'b000, 1'b0, 400);
        apply_m(3'b111, 1'b1, 401);
        for (int k = 0; k < 6; k++) apply_m(3'b111, 1'b0, 500 + k);
        apply_m(3'b000, 1'b1, 600);
        for (int k = 0; k < 5; k++) apply_m(3'b111, 1'b0, 700 + k);
        @(negedge clk);
        pop_chk();

        #1 rst = 1'b1;
        #1;
        chk("async_rst_ce", 32'(ce), 0);
        chk("async_rst_tgl", 32'(tgl), 0);
        chk("async_rst_ready", 32'(ready), 0);
        @(posedge clk);
        #2;
        chk("held_rst_ce", 32'(ce), 0);
        chk("held_rst_ready", 32'(ready), 0);
        rst = 1'b0;
        run_table(1000);
        @(negedge clk);
        pop_chk();

        for (int k = 0; k < 40000 && !rate_done; k++) @(negedge clk);
        chk("rate_done", 32'(rate_done), 1);
        chk("rate_lock", 32'(rate_locked), 1);
        checks++;
        if (rate_cnt != 4194 && rate_cnt != 4195) begin
            errors++;
            $display("FAIL rate_count got %0d exp 4194 or 4195", rate_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
